// File: rtl/draw_engine.sv
// draw_engine: instruction-driven pixel generator feeding the VGA plot port.
// Takes one instruction per start/finished handshake and emits one pixel per
// clock. Operations: NOP, PIXEL, RECT and optional CLEAR. Off-screen pixels
// are clipped, and the plotted-pixel count (or an error code) goes to result.
//
// Build option: define DRAW_ENGINE_CLEAR_EN to enable opcode 3 (CLEAR).
// Without it, opcode 3 is treated as an illegal opcode.
module draw_engine #(
   parameter int X_WIDTH      = 8,
   parameter int Y_WIDTH      = 7,
   parameter int COLOUR_WIDTH = 3,
   parameter int OPCODE_WIDTH = 4,
   parameter int RESULT_WIDTH = 16,
   parameter int SCREEN_W     = 160,
   parameter int SCREEN_H     = 120,
   localparam int IW = OPCODE_WIDTH + 2*X_WIDTH + 2*Y_WIDTH + COLOUR_WIDTH
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [IW-1:0]           instruction,
   output logic [RESULT_WIDTH-1:0] result,
   output logic [X_WIDTH-1:0]      x,
   output logic [Y_WIDTH-1:0]      y,
   output logic [COLOUR_WIDTH-1:0] colour,
   output logic                    plot,
   output logic                    finished
);

   // Instruction layout, MSB first (x0 sits in the LSBs).
   typedef struct packed {
      logic [OPCODE_WIDTH-1:0] op;
      logic [Y_WIDTH-1:0]      h;
      logic [X_WIDTH-1:0]      w;
      logic [COLOUR_WIDTH-1:0] col;
      logic [Y_WIDTH-1:0]      y0;
      logic [X_WIDTH-1:0]      x0;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [31:0]             SW      = SCREEN_W;
   localparam logic [31:0]             SH      = SCREEN_H;
   localparam logic [RESULT_WIDTH-1:0] CNT_MAX = {{(RESULT_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [RESULT_WIDTH-1:0] ERR_RES = '1;
`ifdef DRAW_ENGINE_CLEAR_EN
   localparam logic [X_WIDTH-1:0]      CLR_W   = X_WIDTH'(SCREEN_W - 1);
   localparam logic [Y_WIDTH-1:0]      CLR_H   = Y_WIDTH'(SCREEN_H - 1);
`endif

   instr_t ins;
   assign ins = instr_t'(instruction);

   state_t                  state;
   // Latched per-instruction parameters: base coordinate and column/row limits.
   logic [X_WIDTH-1:0]      bx;
   logic [Y_WIDTH-1:0]      by;
   logic [X_WIDTH-1:0]      lim_w;
   logic [Y_WIDTH-1:0]      lim_h;
   // Offset of the pixel currently on x/y, relative to the base coordinate.
   logic [X_WIDTH-1:0]      cx;
   logic [Y_WIDTH-1:0]      cy;
   // Plotted pixels so far, including the one currently on the outputs.
   logic [RESULT_WIDTH-1:0] cnt;
   // Result held back for the DONE cycle of NOP/illegal opcodes.
   logic [RESULT_WIDTH-1:0] pend_res;

   function automatic logic on_screen(input logic [X_WIDTH-1:0] px,
                                      input logic [Y_WIDTH-1:0] py);
      return (32'(px) < SW) && (32'(py) < SH);
   endfunction

   function automatic logic [RESULT_WIDTH-1:0] sat_inc(input logic [RESULT_WIDTH-1:0] c,
                                                       input logic inc);
      return (inc && (c != CNT_MAX)) ? c + 1'b1 : c;
   endfunction

   // Decode the incoming instruction. PIXEL is a 1x1 rectangle and CLEAR is a
   // full-screen rectangle from the origin, so DRAW only ever walks a rectangle.
   logic               dec_draw;
   logic               dec_illegal;
   logic [X_WIDTH-1:0] dec_x0;
   logic [Y_WIDTH-1:0] dec_y0;
   logic [X_WIDTH-1:0] dec_w;
   logic [Y_WIDTH-1:0] dec_h;
   logic               dec_vis;

   // Opcode decode and rectangle setup for the incoming instruction.
   always_comb begin
      dec_draw    = 1'b0;
      dec_illegal = 1'b0;
      dec_x0      = ins.x0;
      dec_y0      = ins.y0;
      dec_w       = '0;
      dec_h       = '0;
      case (ins.op)
         OPCODE_WIDTH'(0): ;
         OPCODE_WIDTH'(1): dec_draw = 1'b1;
         OPCODE_WIDTH'(2): begin
            dec_draw = 1'b1;
            dec_w    = ins.w;
            dec_h    = ins.h;
         end
`ifdef DRAW_ENGINE_CLEAR_EN
         OPCODE_WIDTH'(3): begin
            dec_draw = 1'b1;
            dec_x0   = '0;
            dec_y0   = '0;
            dec_w    = CLR_W;
            dec_h    = CLR_H;
         end
`endif
         default: dec_illegal = 1'b1;
      endcase
      dec_vis = on_screen(dec_x0, dec_y0);
   end

   // Next raster position. Termination uses the offset counters rather than
   // the wrapped coordinates, so a full 2^X_WIDTH-wide rectangle still ends.
   logic               col_end;
   logic               last;
   logic [X_WIDTH-1:0] ncx;
   logic [Y_WIDTH-1:0] ncy;
   logic [X_WIDTH-1:0] nx;
   logic [Y_WIDTH-1:0] ny;
   logic               nvis;

   // Advance offsets in raster order (x inner) and wrap the coordinates.
   always_comb begin
      col_end = (cx == lim_w);
      last    = col_end && (cy == lim_h);
      ncx     = col_end ? '0 : cx + 1'b1;
      ncy     = col_end ? cy + 1'b1 : cy;
      nx      = bx + ncx;
      ny      = by + ncy;
      nvis    = on_screen(nx, ny);
   end

   // Control FSM with registered pixel outputs and result.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state    <= S_IDLE;
         bx       <= '0;
         by       <= '0;
         lim_w    <= '0;
         lim_h    <= '0;
         cx       <= '0;
         cy       <= '0;
         cnt      <= '0;
         pend_res <= '0;
         result   <= '0;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
         plot     <= 1'b0;
         finished <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               plot <= 1'b0;
               if (start) begin
                  finished <= 1'b0;
                  if (dec_draw) begin
                     state  <= S_DRAW;
                     bx     <= dec_x0;
                     by     <= dec_y0;
                     lim_w  <= dec_w;
                     lim_h  <= dec_h;
                     cx     <= '0;
                     cy     <= '0;
                     x      <= dec_x0;
                     y      <= dec_y0;
                     colour <= ins.col;
                     plot   <= dec_vis;
                     cnt    <= dec_vis ? RESULT_WIDTH'(1) : '0;
                  end else begin
                     state    <= S_DONE;
                     pend_res <= dec_illegal ? ERR_RES : '0;
                  end
               end
            end
            S_DRAW: begin
               if (last) begin
                  state    <= S_IDLE;
                  plot     <= 1'b0;
                  finished <= 1'b1;
                  result   <= cnt;
               end else begin
                  cx   <= ncx;
                  cy   <= ncy;
                  x    <= nx;
                  y    <= ny;
                  plot <= nvis;
                  cnt  <= sat_inc(cnt, nvis);
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               plot     <= 1'b0;
               finished <= 1'b1;
               result   <= pend_res;
            end
            default: begin
               state    <= S_IDLE;
               plot     <= 1'b0;
               finished <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_draw_engine.sv
// tb_draw_engine: directed checks of draw_engine handshake, raster order,
// clipping, result reporting, busy-start rejection and mid-draw reset.
module tb_draw_engine;

   localparam int IW = 4 + 2*8 + 2*7 + 3;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic [IW-1:0] instruction = '0;
   logic [15:0]   result;
   logic [7:0]    x;
   logic [6:0]    y;
   logic [2:0]    colour;
   logic          plot;
   logic          finished;

   int ntot = 0;
   int npass = 0;

   draw_engine dut (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start),
      .instruction (instruction),
      .result      (result),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .plot        (plot),
      .finished    (finished)
   );

   // 10-unit clock.
   always #5 clock = ~clock;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      assert (got === exp) npass++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [6:0] h,
                                        input logic [7:0] w, input logic [2:0] col,
                                        input logic [6:0] y0, input logic [7:0] x0);
      return {op, h, w, col, y0, x0};
   endfunction

   // Directed test sequence.
   initial begin
      int bad;
      int ex;
      int ey;

      // Reset state.
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
      chk("rst_result", result, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_colour", colour, 0);
      chk("rst_plot", plot, 0);
      chk("rst_finished", finished, 1);

      // PIXEL (10,20) colour 5.
      instruction = mk(4'd1, 7'd9, 8'd9, 3'd5, 7'd20, 8'd10);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("pix_plot", plot, 1);
      chk("pix_x", x, 10);
      chk("pix_y", y, 20);
      chk("pix_colour", colour, 5);
      chk("pix_busy", finished, 0);
      step();
      chk("pix_finished", finished, 1);
      chk("pix_plot_off", plot, 0);
      chk("pix_result", result, 1);

      // RECT at (158,0), 4x2, right half clipped.
      instruction = mk(4'd2, 7'd1, 8'd3, 3'd4, 7'd0, 8'd158);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         ex = (158 + k % 4) % 256;
         ey = k / 4;
         chk("rect_x", x, ex);
         chk("rect_y", y, ey);
         chk("rect_plot", plot, (ex < 160) ? 1 : 0);
         chk("rect_busy", finished, 0);
         step();
      end
      chk("rect_finished", finished, 1);
      chk("rect_result", result, 4);
      chk("rect_hold_x", x, 161);
      chk("rect_hold_y", y, 1);
      chk("rect_plot_off", plot, 0);

      // CLEAR colour 2 (x0/y0/w/h must not matter).
      instruction = mk(4'd3, 7'd5, 8'd5, 3'd2, 7'd3, 8'd7);
      start = 1'b1;
      step();
      start = 1'b0;
`ifdef DRAW_ENGINE_CLEAR_EN
      bad = 0;
      for (int k = 0; k < 19200; k++) begin
         if (plot !== 1'b1 || x !== 8'(k % 160) || y !== 7'(k / 160) ||
             colour !== 3'd2 || finished !== 1'b0)
            bad++;
         if (k == 19199) begin
            chk("clear_last_x", x, 159);
            chk("clear_last_y", y, 119);
         end
         step();
      end
      chk("clear_seq_errors", bad, 0);
      chk("clear_finished", finished, 1);
      chk("clear_result", result, 19200);
`else
      chk("clear_off_plot", plot, 0);
      chk("clear_off_busy", finished, 0);
      step();
      chk("clear_off_finished", finished, 1);
      chk("clear_off_result", result, 16'hFFFF);
`endif

      // Illegal opcode 7.
      instruction = mk(4'd7, 7'd2, 8'd2, 3'd1, 7'd1, 8'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ill_plot", plot, 0);
      chk("ill_busy", finished, 0);
      step();
      chk("ill_finished", finished, 1);
      chk("ill_result", result, 16'hFFFF);

      // NOP.
      instruction = mk(4'd0, 7'd2, 8'd2, 3'd1, 7'd1, 8'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("nop_plot", plot, 0);
      chk("nop_busy", finished, 0);
      step();
      chk("nop_finished", finished, 1);
      chk("nop_result", result, 0);

      // RECT 4x4 at (4,6); start pulsed while busy and instruction changed.
      instruction = mk(4'd2, 7'd3, 8'd3, 3'd6, 7'd6, 8'd4);
      start = 1'b1;
      step();
      start = 1'b0;
      instruction = mk(4'd1, 7'd0, 8'd0, 3'd1, 7'd50, 8'd50);
      for (int k = 0; k < 16; k++) begin
         if (k == 2) start = 1'b1;
         if (k == 3) start = 1'b0;
         chk("busy_x", x, 4 + k % 4);
         chk("busy_y", y, 6 + k / 4);
         chk("busy_plot", plot, 1);
         chk("busy_colour", colour, 6);
         step();
      end
      chk("busy_finished", finished, 1);
      chk("busy_result", result, 16);
      step();
      chk("busy_no_restart", finished, 1);

      // Reset during cycle T+5 of a 16-pixel RECT.
      instruction = mk(4'd2, 7'd3, 8'd3, 3'd1, 7'd30, 8'd20);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      step();
      chk("abort_pre_x", x, 20);
      chk("abort_pre_y", y, 31);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("abort_plot", plot, 0);
      chk("abort_finished", finished, 1);
      chk("abort_result", result, 0);

      // PIXEL after abort runs normally.
      instruction = mk(4'd1, 7'd0, 8'd0, 3'd3, 7'd2, 8'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("post_plot", plot, 1);
      chk("post_x", x, 1);
      chk("post_y", y, 2);
      chk("post_colour", colour, 3);
      step();
      chk("post_finished", finished, 1);
      chk("post_result", result, 1);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/draw_engine.md
# draw_engine

Parametrised instruction-driven pixel generator that sits between the instruction sequencer and the VGA adapter's plot port. It accepts one drawing instruction per start/finished handshake and emits one pixel per clock. Supported operations are single pixel, filled rectangle and optional full-screen clear. Pixels outside the screen are clipped, and the block reports a pixel count or error code in `result`.

## Interface
- `X_WIDTH`, 8, x coordinate width
- `Y_WIDTH`, 7, y coordinate width
- `COLOUR_WIDTH`, 3, colour width
- `OPCODE_WIDTH`, 4, opcode field width
- `RESULT_WIDTH`, 16, result width
- `SCREEN_W`, 160, visible columns; x ≥ SCREEN_W is clipped
- `SCREEN_H`, 120, visible rows; y ≥ SCREEN_H is clipped
- `clock`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `start`  in  1  request; sampled only while `finished`=1
- `instruction`  in  IW = OPCODE_WIDTH+2·X_WIDTH+2·Y_WIDTH+COLOUR_WIDTH  instruction word; fields are defined under Operation
- `result`  out  RESULT_WIDTH  outcome of last completed instruction
- `x`  out  X_WIDTH  pixel x
- `y`  out  Y_WIDTH  pixel y
- `colour`  out  COLOUR_WIDTH  pixel colour
- `plot`  out  1  pixel write strobe, one pixel per cycle
- `finished`  out  1  1 = idle and ready

## Operation
- Instruction fields, from LSB to MSB: `x0`[X_WIDTH], `y0`[Y_WIDTH], `col`[COLOUR_WIDTH], `w`[X_WIDTH], `h`[Y_WIDTH], `op`[OPCODE_WIDTH] (top bits).
- The whole instruction is latched at the edge where `start`=1 and `finished`=1; the input may change afterwards.
- `start` while busy is ignored.
- States:
  - IDLE: `finished`=1. Sampling `start` moves to DRAW for op 1/2/3, or DONE for op 0/illegal.
  - DRAW: emits one pixel per cycle. Leaves after the last pixel.
  - DONE: one cycle with `plot`=0, then IDLE.
- Opcodes:
  - 0 NOP: no pixels, `result`=0.
  - 1 PIXEL: one pixel at (`x0`,`y0`).
  - 2 RECT: (`w`+1)·(`h`+1) pixels in raster order, x inner, starting at (`x0`,`y0`). `w` and `h` are ignored for every other opcode.
  - 3 CLEAR: SCREEN_W·SCREEN_H pixels from (0,0) in raster order, colour `col`.
- Coordinates: x = (`x0`+i) mod 2^X_WIDTH and y = (`y0`+j) mod 2^Y_WIDTH. The wrapped value is driven on `x`/`y`.
- Clipping: if wrapped x ≥ SCREEN_W or y ≥ SCREEN_H, `plot`=0 that cycle. The cycle is still consumed and is not counted.
- `result` counts plotted (unclipped) pixels and saturates at 2^RESULT_WIDTH−2.
- `result` is all-ones for an illegal opcode.
- `result` updates only on the transition into IDLE and holds otherwise.
- `colour` = `col` throughout DRAW and holds its last value outside DRAW.
- In DONE and IDLE, `plot`=0 and `x`/`y` hold their last values.

## Timing
- Reset values: `result`=0, `x`=0, `y`=0, `colour`=0, `plot`=0, `finished`=1, state IDLE.
- Reset has priority over everything. Asserting it mid-DRAW aborts immediately; the aborted instruction does not update `result`.
- Edge T samples `start`. From T+1, `finished`=0 and the first pixel is on `x`/`y`/`plot`.
- An N-pixel instruction occupies cycles T+1 … T+N. At edge T+N+1, `finished`=1 and `result` is valid.
- PIXEL: `finished` rises at T+2.
- NOP/illegal: cycle T+1 in DONE with `finished`=0; `finished` rises at T+2.
- Back-to-back: `start` held high is accepted again at the edge `finished` is first seen high. No additional gap is required.
- Counters: x counter is X_WIDTH bits; row counter is Y_WIDTH bits. Rectangle termination compares counters against `w`/`h`, not against wrapped coordinates, so `w`=2^X_WIDTH−1 yields exactly 2^X_WIDTH columns.

## Configuration
- `DRAW_ENGINE_CLEAR_EN` defined: opcode 3 is CLEAR, as specified above.
- Not defined: the CLEAR logic is omitted. Opcode 3 is illegal: DONE cycle, `result`=all-ones, no plot.

## Test plan
- Reset, then PIXEL `x0`=10, `y0`=20, `col`=5 → at T+1 exactly one cycle with `plot`=1, `x`=10, `y`=20, `colour`=5; `finished`=1 at T+2; `result`=1.
- RECT `x0`=158, `y0`=0, `w`=3, `h`=1 → 8 DRAW cycles, x sequence 158,159,160,161 per row. `plot`=1 only for x=158/159; `result`=4; `finished` rises at T+9.
- CLEAR `col`=2 (macro defined) → 19200 consecutive `plot`=1 cycles ending at (159,119), `result`=19200. Same stimulus with macro undefined → no plot, `result`=16'hFFFF.
- Illegal opcode 7, then NOP → no plot; `result`=16'hFFFF, then `result`=0. Each instruction returns `finished`=1 after 2 edges.
- RECT `w`=3, `h`=3 with `start` pulsed again at cycle T+3 and `instruction` changed after T → the second `start` is ignored; the original 16 pixels are emitted unchanged.
- `resetn`=0 at cycle T+5 of a 16-pixel RECT → next cycle `plot`=0, `finished`=1, `result`=0. The following PIXEL executes normally.
